// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// Macro PIPE_HAZARD_STALL_CNT_EN adds the stall_cnt performance counter.
interface pipe_hazard_ctrl_if;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_rs_tuse;
    logic [1:0]  d_rt_tuse;
    logic [4:0]  e_wa;
    logic [4:0]  m_wa;
    logic [1:0]  e_tnew;
    logic [1:0]  m_tnew;
    logic        d_md;
    logic        e_md_start;
    logic        e_md_div;
    logic        int_req;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        flush_all;
    logic        pc_sel_eh;
    logic        md_busy;
`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output d_rs, d_rt, d_rs_tuse, d_rt_tuse, e_wa, m_wa, e_tnew, m_tnew,
        output d_md, e_md_start, e_md_div, int_req,
`ifdef PIPE_HAZARD_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  stall_f, stall_d, flush_e, flush_all, pc_sel_eh, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, e_wa, m_wa, e_tnew, m_tnew,
        input  d_md, e_md_start, e_md_div, int_req,
`ifdef PIPE_HAZARD_STALL_CNT_EN
        output stall_cnt,
`endif
        output stall_f, stall_d, flush_e, flush_all, pc_sel_eh, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: data/mult-div stalls, interrupt flush FSM, mult/div busy timer.
// Optional macro PIPE_HAZARD_STALL_CNT_EN adds a 32-bit stall-cycle counter.
module pipe_hazard_ctrl (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       rs_stall, rt_stall, data_stall, md_stall, stall, int_taken;

    // A source stalls only if its value is needed before the producer can forward it.
    assign rs_stall = (hz.d_rs != 5'd0) &&
                      (((hz.d_rs == hz.e_wa) && (hz.d_rs_tuse < hz.e_tnew)) ||
                       ((hz.d_rs == hz.m_wa) && (hz.d_rs_tuse < hz.m_tnew)));
    assign rt_stall = (hz.d_rt != 5'd0) &&
                      (((hz.d_rt == hz.e_wa) && (hz.d_rt_tuse < hz.e_tnew)) ||
                       ((hz.d_rt == hz.m_wa) && (hz.d_rt_tuse < hz.m_tnew)));

    assign data_stall = rs_stall || rt_stall;
    assign hz.md_busy = (md_cnt_q != 4'd0);
    assign md_stall   = hz.d_md && (hz.md_busy || hz.e_md_start);
    assign stall      = data_stall || md_stall;
    assign int_taken  = (state_q == RUN) && hz.int_req;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        state_d      = state_q;
        hz.stall_f   = 1'b0;
        hz.stall_d   = 1'b0;
        hz.flush_e   = 1'b0;
        hz.flush_all = 1'b0;
        hz.pc_sel_eh = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.int_req) begin
                    hz.flush_all = 1'b1;
                    state_d      = FLUSH;
                end else if (stall) begin
                    hz.stall_f = 1'b1;
                    hz.stall_d = 1'b1;
                    hz.flush_e = 1'b1;
                end
            end
            FLUSH: begin
                hz.pc_sel_eh = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // A start in the same cycle as a taken interrupt belongs to a cancelled instruction.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.e_md_start && !int_taken)
            md_cnt_d = hz.e_md_div ? 4'd10 : 4'd5;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= 32'd0;
        else if (hz.stall_f)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif
endmodule
